// File: rtl/ara_compl_sync.sv
// ---------------------------------------------------------------------------
// ara_compl_sync
//
// System-level completion synchronizer for a multi-cluster Ara ring. Every
// cluster reports per-VFU completion pulses. For each VFU the block keeps a
// pending count per cluster. When every active cluster holds at least one
// count, the block broadcasts one release pulse on that VFU and takes one
// count from every active cluster.
//
// Parameters
//   NrClusters     : number of Ara macros (>= 1)
//   NrVFUs         : completion bits per cluster (matches ara_pkg::NrVFUs)
//   MaxOutstanding : saturation value of each pending counter (>= 1)
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   rst_i          : synchronous, active-high reset
//   pe_compl_i     : [NrClusters][NrVFUs] completion pulses from the clusters
//   active_mask_i  : [NrClusters] clusters taking part in synchronization
//   pe_compl_o     : [NrVFUs] registered release pulse, broadcast to all
//   overflow_o     : [NrVFUs] sticky flag, a saturated counter dropped a pulse
//   pending_o      : [NrVFUs] some active cluster has a nonzero count
// ---------------------------------------------------------------------------
module ara_compl_sync #(
    parameter int unsigned NrClusters     = 4,
    parameter int unsigned NrVFUs         = 7,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NrClusters-1:0][NrVFUs-1:0]    pe_compl_i,
    input  logic [NrClusters-1:0]                active_mask_i,
    output logic [NrVFUs-1:0]                    pe_compl_o,
    output logic [NrVFUs-1:0]                    overflow_o,
    output logic [NrVFUs-1:0]                    pending_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] OneCnt = CntWidth'(1);

    logic [NrClusters-1:0][NrVFUs-1:0][CntWidth-1:0] cnt_q;
    logic [NrClusters-1:0][NrVFUs-1:0][CntWidth-1:0] cnt_d;
    logic [NrClusters-1:0][NrVFUs-1:0]               inc;
    logic [NrClusters-1:0][NrVFUs-1:0]               dec;
    logic [NrVFUs-1:0]                               rel_now;
    logic [NrVFUs-1:0]                               overflow_d;

    // Release decision looks only at registered counters, so a pulse arriving
    // in the same cycle never short-circuits the collection. Inactive clusters
    // are treated as ready; an empty mask never releases.
    always_comb begin
        rel_now = '0;
        for (int unsigned v = 0; v < NrVFUs; v++) begin
            rel_now[v] = |active_mask_i;
            for (int unsigned c = 0; c < NrClusters; c++) begin
                if (active_mask_i[c] && (cnt_q[c][v] == '0)) begin
                    rel_now[v] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned c = 0; c < NrClusters; c++) begin
            for (int unsigned v = 0; v < NrVFUs; v++) begin
                inc[c][v] = pe_compl_i[c][v] & active_mask_i[c];
                dec[c][v] = rel_now[v] & active_mask_i[c];
            end
        end
    end

    // Counter next state. A simultaneous increment and release is a net zero
    // and holds the count; it cannot overflow. An inactive cluster has neither
    // inc nor dec, so it keeps whatever it held until it is reactivated.
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_o;
        for (int unsigned c = 0; c < NrClusters; c++) begin
            for (int unsigned v = 0; v < NrVFUs; v++) begin
                if (inc[c][v] && !dec[c][v]) begin
                    if (cnt_q[c][v] == MaxCnt) begin
                        overflow_d[v] = 1'b1;
                    end else begin
                        cnt_d[c][v] = cnt_q[c][v] + OneCnt;
                    end
                end else if (dec[c][v] && !inc[c][v]) begin
                    // dec implies a nonzero count, so this cannot underflow.
                    cnt_d[c][v] = cnt_q[c][v] - OneCnt;
                end
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int unsigned v = 0; v < NrVFUs; v++) begin
            for (int unsigned c = 0; c < NrClusters; c++) begin
                if (active_mask_i[c] && (cnt_q[c][v] != '0)) begin
                    pending_o[v] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            pe_compl_o <= '0;
            overflow_o <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pe_compl_o <= rel_now;
            overflow_o <= overflow_d;
        end
    end

endmodule
